traffic_display: RTL and testbench

- Consumer end of the traffic-controller output interface.
- Samples the two BCD countdowns (ACOUNT/BCOUNT) and one-hot lamp codes (LAMPA/LAMPB) and drives a 4-digit multiplexed 7-segment display.
- Drives lamp LEDs with a blinking yellow phase.
- Monitors the interface for safety and encoding faults, with sticky error reporting.

---
 rtl/traffic_display_if.sv | 24 ++
 rtl/traffic_display.sv | 144 ++++++++++++++
 tb/tb_traffic_display.sv | 129 ++++++++++++
 3 files changed

// File: rtl/traffic_display_if.sv
// Traffic-controller output bundle as seen by the display: countdowns and lamp
// codes in, segment/digit/LED drive and fault status out.
interface traffic_display_if;
    logic [7:0] ACOUNT;
    logic [7:0] BCOUNT;
    logic [3:0] LAMPA;
    logic [3:0] LAMPB;
    logic [7:0] SEG;
    logic [3:0] DIG;
    logic [3:0] LEDA;
    logic [3:0] LEDB;
    logic       ERR;
    logic [2:0] ERRCODE;

    modport master (
        output ACOUNT, BCOUNT, LAMPA, LAMPB,
        input  SEG, DIG, LEDA, LEDB, ERR, ERRCODE
    );

    modport slave (
        input  ACOUNT, BCOUNT, LAMPA, LAMPB,
        output SEG, DIG, LEDA, LEDB, ERR, ERRCODE
    );
endinterface

// File: rtl/traffic_display.sv
// Consumer of the traffic-controller outputs: 4-digit multiplexed 7-segment
// display, blinking lamp LEDs, and sticky interface fault monitor.
module traffic_display #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 250000
) (
    input  logic             CLK,
    input  logic             RST,
    traffic_display_if.slave bus
);
    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [23:0] BLINK_LAST = 24'(BLINK_DIV - 1);

    logic [15:0] r_scan_cnt;
    logic [1:0]  r_idx;
    logic [23:0] r_blink_cnt;
    logic        r_blink_ph;
    logic [7:0]  r_sha;
    logic [7:0]  r_shb;
    logic        r_conf_filt;
    logic [7:0]  r_seg;
    logic [3:0]  r_dig;
    logic [3:0]  r_leda;
    logic [3:0]  r_ledb;
    logic        r_err;
    logic [2:0]  r_errcode;

    logic        w_capture;
    logic        w_scan_wrap;
    logic        w_blink_wrap;
    logic        w_overlap;
    logic [2:0]  w_faults;
    logic [7:0]  w_seg;
    logic [3:0]  w_dig;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [3:0] l);
        return l inside {4'd1, 4'd2, 4'd4, 4'd8};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Tens digit blanks only for a leading zero in front of a real digit.
    function automatic logic [7:0] tens_seg(input logic [7:0] v);
        if (v[7:4] == 4'd0 && v[3:0] <= 4'd9) return 8'h00;
        return {1'b0, seg7(v[7:4])};
    endfunction

    function automatic logic [7:0] units_seg(input logic [7:0] v);
        return {(v[7:4] == 4'd0) && (v[3:0] <= 4'd5), seg7(v[3:0])};
    endfunction

    function automatic logic [3:0] led_of(input logic [3:0] l, input logic ph);
        if (!is_onehot(l)) return 4'd8;
        if (l == 4'd4)     return ph ? 4'd4 : 4'd0;
        return l;
    endfunction

    assign w_capture    = (r_idx == 2'd0) && (r_scan_cnt == 16'd0);
    assign w_scan_wrap  = (r_scan_cnt == SCAN_LAST);
    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
    assign w_overlap    = (bus.LAMPA != 4'd8) && (bus.LAMPB != 4'd8);

    assign w_faults = {
        w_capture && !(bcd_ok(bus.ACOUNT) && bcd_ok(bus.BCOUNT)),
        !is_onehot(bus.LAMPA) || !is_onehot(bus.LAMPB),
        w_overlap && r_conf_filt
    };

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        w_seg = 8'h00;
        w_dig = ~(4'b0001 << r_idx);
        case (r_idx)
            2'd0: w_seg = tens_seg(r_sha);
            2'd1: w_seg = units_seg(r_sha);
            2'd2: w_seg = tens_seg(r_shb);
            2'd3: w_seg = units_seg(r_shb);
            default: w_seg = 8'h00;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_scan_cnt  <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
            r_sha       <= '0;
            r_shb       <= '0;
            r_conf_filt <= 1'b0;
            r_seg       <= 8'h00;
            r_dig       <= 4'b1111;
            r_leda      <= 4'd8;
            r_ledb      <= 4'd8;
            r_err       <= 1'b0;
            r_errcode   <= '0;
        end else begin
            r_scan_cnt <= w_scan_wrap ? 16'd0 : r_scan_cnt + 16'd1;
            if (w_scan_wrap) r_idx <= r_idx + 2'd1;

            r_blink_cnt <= w_blink_wrap ? 24'd0 : r_blink_cnt + 24'd1;
            if (w_blink_wrap) r_blink_ph <= ~r_blink_ph;

            if (w_capture) begin
                r_sha <= bus.ACOUNT;
                r_shb <= bus.BCOUNT;
            end

            r_conf_filt <= w_overlap;
            r_seg       <= w_seg;
            r_dig       <= w_dig;
            r_leda      <= led_of(bus.LAMPA, r_blink_ph);
            r_ledb      <= led_of(bus.LAMPB, r_blink_ph);
            r_errcode   <= r_errcode | w_faults;
            r_err       <= r_err | (|w_faults);
        end
    end

    assign bus.SEG     = r_seg;
    assign bus.DIG     = r_dig;
    assign bus.LEDA    = r_leda;
    assign bus.LEDB    = r_ledb;
    assign bus.ERR     = r_err;
    assign bus.ERRCODE = r_errcode;
endmodule

// File: tb/tb_traffic_display.sv
// Directed bench for traffic_display with SCAN_DIV=4, BLINK_DIV=8; edge numbers
// in comments count rising edges, E0 being the reset edge.
module tb_traffic_display;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp;
    int   n_fail;

    traffic_display_if bus ();

    traffic_display #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input logic [7:0] seg, input logic [3:0] dig);
        check({tag, ".seg"}, bus.SEG, seg);
        check({tag, ".dig"}, {4'h0, bus.DIG}, {4'h0, dig});
    endtask

    task automatic check_err(input string tag, input logic err, input logic [2:0] code);
        check({tag, ".err"}, {7'h0, bus.ERR}, {7'h0, err});
        check({tag, ".code"}, {5'h0, bus.ERRCODE}, {5'h0, code});
    endtask

    task automatic check_reset(input string tag);
        check_disp(tag, 8'h00, 4'b1111);
        check({tag, ".leda"}, {4'h0, bus.LEDA}, 8'h08);
        check({tag, ".ledb"}, {4'h0, bus.LEDB}, 8'h08);
        check_err(tag, 1'b0, 3'b000);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.ACOUNT = 8'h40;
        bus.BCOUNT = 8'h05;
        bus.LAMPA  = 4'd8;
        bus.LAMPB  = 4'd8;

        step(1);                          // E0
        check_reset("reset");
        rst = 1'b0;

        // Scan order and decode; E1 still shows the pre-capture (zero) shadow.
        step(1);  check_disp("e1_a_tens_old", 8'h00, 4'b1110);
        step(1);  check_disp("e2_a_tens", 8'h66, 4'b1110);
        step(4);  check_disp("e6_a_units", 8'h3F, 4'b1101);
        step(4);  check_disp("e10_b_tens_blank", 8'h00, 4'b1011);

        // Mid-frame change at idx=2 must wait for the next frame.
        bus.ACOUNT = 8'h39;
        step(4);  check_disp("e14_b_units_dp", 8'hED, 4'b0111);
        step(4);  check_disp("e18_new_a_tens", 8'h4F, 4'b1110);
        step(4);  check_disp("e22_new_a_units", 8'h6F, 4'b1101);

        // Yellow blink: phase after edge k is (k/8)%2.
        bus.LAMPA = 4'd4;
        step(2);  check("e24_blink_dark", {4'h0, bus.LEDA}, 8'h00);
        step(1);  check("e25_blink_lit", {4'h0, bus.LEDA}, 8'h04);
        step(7);  check("e32_blink_lit", {4'h0, bus.LEDA}, 8'h04);
        step(1);  check("e33_blink_dark", {4'h0, bus.LEDA}, 8'h00);
        step(8);  check("e41_blink_lit", {4'h0, bus.LEDA}, 8'h04);
        check_err("e41_clean", 1'b0, 3'b000);
        bus.LAMPA = 4'd2;
        step(1);  check("e42_green", {4'h0, bus.LEDA}, 8'h02);

        // Single-cycle overlap is filtered; two cycles are flagged.
        bus.LAMPB = 4'd2;
        step(1);  check_err("e43_overlap1", 1'b0, 3'b000);
        bus.LAMPB = 4'd8;
        step(1);  check_err("e44_overlap_gone", 1'b0, 3'b000);
        bus.LAMPB = 4'd2;
        step(1);  check_err("e45_overlap1_again", 1'b0, 3'b000);
        step(1);  check_err("e46_conflict", 1'b1, 3'b001);
        bus.LAMPB = 4'd8;
        step(3);  check_err("e49_sticky", 1'b1, 3'b001);

        // Not one-hot lamp: fail-safe red and sticky flag.
        bus.LAMPB = 4'b0110;
        step(1);
        check("e50_failsafe", {4'h0, bus.LEDB}, 8'h08);
        check_err("e50_onehot", 1'b1, 3'b011);

        // Bad BCD only flagged on the capture cycle (state after E64).
        bus.LAMPB  = 4'd8;
        bus.ACOUNT = 8'h3C;
        step(14); check_err("e64_pre_capture", 1'b1, 3'b011);
        step(1);  check_err("e65_bad_bcd", 1'b1, 3'b111);
        step(1);  check_disp("e66_tens_3", 8'h4F, 4'b1110);
        step(4);  check_disp("e70_units_dash", 8'h40, 4'b1101);

        // Zero tens with an illegal units digit is not blanked.
        bus.ACOUNT = 8'h0C;
        step(12); check_disp("e82_tens_zero_shown", 8'h3F, 4'b1110);
        step(4);  check_disp("e86_units_dash", 8'h40, 4'b1101);

        // Reset mid-frame with faults latched and a green lamp present.
        rst = 1'b1;
        step(1);  check_reset("midreset");
        rst = 1'b0;
        bus.ACOUNT = 8'h40;
        bus.LAMPA  = 4'd8;
        step(1);  check_disp("r1_restart", 8'h00, 4'b1110);
        step(1);  check_disp("r2_a_tens", 8'h66, 4'b1110);
        step(4);  check_disp("r6_a_units", 8'h3F, 4'b1101);
        check_err("r6_clean", 1'b0, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
